sddt_maint_arbiter: RTL

Sits on the 128-bit command stream between `ps_interface` (M_AXIS_CMD) and `sddt_core` (S_AXIS_CMD), in the `c0_ddr4_clk` domain. It merges host commands with internally generated DDR4 maintenance sequences (periodic refresh and ZQ calibration) into one in-order stream. Refresh may be postponed up to the DDR4 limit, and postponement overflow is reported.

---
 rtl/sddt_maint_arbiter_pkg.sv | 34 +++
 rtl/maint_interval_timer.sv | 25 ++
 rtl/sddt_maint_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sddt_maint_arbiter_pkg.sv
// Shared command encoding and FSM state type for the maintenance arbiter.
package sddt_maint_arbiter_pkg;

  localparam int OPC_MSB    = 127;
  localparam int OPC_LSB    = 124;
  localparam int WAIT_CNT_W = 32;

  typedef enum logic [3:0] {
    OPC_WAIT = 4'h0,
    OPC_PREA = 4'h3,
    OPC_REF  = 4'h6,
    OPC_ZQCS = 4'h7
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREA,
    ST_WAIT_RP,
    ST_REF,
    ST_WAIT_RFC,
    ST_ZQ,
    ST_WAIT_ZQ
  } state_e;

  // Build a 128-bit command word: opcode on top, wait count in the low field.
  function automatic logic [127:0] mk_cmd(opcode_e op, logic [WAIT_CNT_W-1:0] cnt);
    logic [127:0] w;
    w = '0;
    w[OPC_MSB:OPC_LSB] = op;
    w[WAIT_CNT_W-1:0] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/maint_interval_timer.sv
// Free-running interval counter; pulses req on its terminal count.
module maint_interval_timer #(
  parameter int unsigned INTERVAL = 5200
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic req
);

  localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CW-1:0] LAST = CW'(INTERVAL - 1);

  logic [CW-1:0] cnt;

  // Count 0..INTERVAL-1 while enabled; disabling parks the count at 0.
  always_ff @(posedge clk) begin
    if (rst || !en) cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end

  assign req = !rst && en && (cnt == LAST);

endmodule

// File: rtl/sddt_maint_arbiter.sv
// Merges host commands with refresh / ZQ maintenance sequences into one stream.
module sddt_maint_arbiter
  import sddt_maint_arbiter_pkg::*;
#(
  parameter int unsigned REF_INTERVAL = 5200,
  parameter int unsigned ZQ_INTERVAL  = 65536,
  parameter int unsigned T_RP         = 10,
  parameter int unsigned T_RFC        = 234,
  parameter int unsigned T_ZQCS       = 128,
  parameter int unsigned URGENT_THR   = 4,
  parameter int unsigned MAX_POSTPONE = 8
) (
  input  logic          c0_ddr4_clk,
  input  logic          c0_ddr4_rst,
  input  logic          maint_en,
  input  logic          per_ref_init,
  input  logic          per_zq_init,
  input  logic [127:0]  S_AXIS_CMD_tdata,
  input  logic          S_AXIS_CMD_tvalid,
  output logic          S_AXIS_CMD_tready,
  output logic [127:0]  M_AXIS_CMD_tdata,
  output logic          M_AXIS_CMD_tvalid,
  input  logic          M_AXIS_CMD_tready,
  output logic [3:0]    ref_pending,
  output logic [15:0]   ref_issued_cnt,
  output logic          maint_busy,
  output logic          maint_err
);

  localparam logic [3:0] URG  = 4'(URGENT_THR);
  localparam logic [4:0] MAXP = 5'(MAX_POSTPONE);

  state_e        state, state_nxt;
  logic          zq_pending, zq_nxt;
  logic [3:0]    pend_nxt;
  logic [4:0]    pend_sum;
  logic          ref_tick, zq_tick;
  logic          slot_free, start, host_rdy;
  logic          load, ref_take, zq_take;
  logic [127:0]  load_data;

  maint_interval_timer #(.INTERVAL(REF_INTERVAL)) u_ref_tmr (
    .clk(c0_ddr4_clk), .rst(c0_ddr4_rst), .en(maint_en), .req(ref_tick)
  );

  maint_interval_timer #(.INTERVAL(ZQ_INTERVAL)) u_zq_tmr (
    .clk(c0_ddr4_clk), .rst(c0_ddr4_rst), .en(maint_en), .req(zq_tick)
  );

  assign slot_free = !M_AXIS_CMD_tvalid || M_AXIS_CMD_tready;
  // A busy host only yields once refresh debt reaches the urgent level.
  assign start = (((ref_pending != 4'd0) || zq_pending) && !S_AXIS_CMD_tvalid)
              || (ref_pending >= URG);

  // Next state and the beat to load; every maintenance state emits one beat.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_data = '0;
    ref_take  = 1'b0;
    zq_take   = 1'b0;
    host_rdy  = 1'b0;
    case (state)
      ST_IDLE: begin
        host_rdy = !start && slot_free;
        if (start) state_nxt = ST_PREA;
        else if (S_AXIS_CMD_tvalid && host_rdy) begin
          load      = 1'b1;
          load_data = S_AXIS_CMD_tdata;
        end
      end
      ST_PREA: if (slot_free) begin
        load      = 1'b1;
        load_data = mk_cmd(OPC_PREA, '0);
        state_nxt = ST_WAIT_RP;
      end
      ST_WAIT_RP: if (slot_free) begin
        load      = 1'b1;
        load_data = mk_cmd(OPC_WAIT, T_RP[31:0]);
        state_nxt = (ref_pending != 4'd0) ? ST_REF : ST_ZQ;
      end
      ST_REF: if (slot_free) begin
        load      = 1'b1;
        ref_take  = 1'b1;
        load_data = mk_cmd(OPC_REF, '0);
        state_nxt = ST_WAIT_RFC;
      end
      ST_WAIT_RFC: if (slot_free) begin
        load      = 1'b1;
        load_data = mk_cmd(OPC_WAIT, T_RFC[31:0]);
        if (ref_pending != 4'd0) state_nxt = ST_REF;
        else if (zq_pending)     state_nxt = ST_ZQ;
        else                     state_nxt = ST_IDLE;
      end
      ST_ZQ: if (slot_free) begin
        load      = 1'b1;
        zq_take   = 1'b1;
        load_data = mk_cmd(OPC_ZQCS, '0);
        state_nxt = ST_WAIT_ZQ;
      end
      ST_WAIT_ZQ: if (slot_free) begin
        load      = 1'b1;
        load_data = mk_cmd(OPC_WAIT, T_ZQCS[31:0]);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request bookkeeping: timer and init pulse may both add in one cycle.
  always_comb begin
    pend_sum = {1'b0, ref_pending} + 5'(ref_tick) + 5'(per_ref_init) - 5'(ref_take);
    pend_nxt = (pend_sum > 5'd15) ? 4'd15 : pend_sum[3:0];
    zq_nxt   = (zq_pending && !zq_take) || zq_tick || per_zq_init;
  end

  // State, counters and the single output slot register.
  always_ff @(posedge c0_ddr4_clk) begin
    if (c0_ddr4_rst) begin
      state             <= ST_IDLE;
      ref_pending       <= '0;
      zq_pending        <= 1'b0;
      ref_issued_cnt    <= '0;
      maint_err         <= 1'b0;
      M_AXIS_CMD_tvalid <= 1'b0;
      M_AXIS_CMD_tdata  <= '0;
    end else begin
      state          <= state_nxt;
      ref_pending    <= pend_nxt;
      zq_pending     <= zq_nxt;
      ref_issued_cnt <= ref_issued_cnt + 16'(ref_take);
      if ({1'b0, pend_nxt} > MAXP) maint_err <= 1'b1;
      if (load) begin
        M_AXIS_CMD_tvalid <= 1'b1;
        M_AXIS_CMD_tdata  <= load_data;
      end else if (slot_free) begin
        M_AXIS_CMD_tvalid <= 1'b0;
      end
    end
  end

  assign S_AXIS_CMD_tready = host_rdy && !c0_ddr4_rst;
  assign maint_busy        = (state != ST_IDLE);

endmodule
